// File: rtl/modadd_ctrl_if.sv
// Bundle between the modular add/sub controller, its requester and the external mpadder.
// master = environment (requester + adder), slave = controller.
interface modadd_ctrl_if #(
  parameter int WIDTH = 1027
);
  logic             start;
  logic             op_sub;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic [WIDTH-1:0] in_m;
  logic [WIDTH-1:0] result;
  logic             done;
  logic             busy;

  logic             add_start;
  logic             add_subtract;
  logic [WIDTH-1:0] add_in_a;
  logic [WIDTH-1:0] add_in_b;
  logic [WIDTH:0]   add_result;
  logic             add_done;

  modport master (
    output start, op_sub, in_a, in_b, in_m, add_result, add_done,
    input  result, done, busy, add_start, add_subtract, add_in_a, add_in_b
  );

  modport slave (
    input  start, op_sub, in_a, in_b, in_m, add_result, add_done,
    output result, done, busy, add_start, add_subtract, add_in_a, add_in_b
  );
endinterface

// File: rtl/modadd_ctrl.sv
// Modular add/subtract sequencer: two passes through an external mpadder (raw op, then
// correction by M), with the correction result selected or discarded at the end.
module modadd_ctrl #(
  parameter int WIDTH = 1027
) (
  input logic          clk,
  input logic          resetn,
  modadd_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE,
    OP1_ISSUE,
    OP1_WAIT,
    OP2_ISSUE,
    OP2_WAIT,
    FIN
  } state_e;

  state_e           state_q, state_d;
  logic             op_sub_q;
  logic [WIDTH-1:0] m_q;
  logic [WIDTH:0]   r1_q, r1_d;
  logic             add_start_q;
  logic             add_sub_q, add_sub_d;
  logic [WIDTH-1:0] add_a_q, add_a_d;
  logic [WIDTH-1:0] add_b_q, add_b_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             done_q;
  logic             busy_q;
  logic             accept;

  // Add: keep R1 when R1 - M borrowed. Sub: keep R1 unless A - B borrowed, else R1 + M.
  function automatic logic [WIDTH-1:0] final_select(input logic sub,
                                                    input logic [WIDTH:0] r1,
                                                    input logic [WIDTH:0] r2);
    if (sub)
      return r1[WIDTH] ? r2[WIDTH-1:0] : r1[WIDTH-1:0];
    else
      return r2[WIDTH] ? r1[WIDTH-1:0] : r2[WIDTH-1:0];
  endfunction

  assign accept = (state_q == IDLE) && bus.start;

  always_comb begin
    state_d   = state_q;
    r1_d      = r1_q;
    add_sub_d = add_sub_q;
    add_a_d   = add_a_q;
    add_b_d   = add_b_q;
    result_d  = result_q;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d   = OP1_ISSUE;
          add_a_d   = bus.in_a;
          add_b_d   = bus.in_b;
          add_sub_d = bus.op_sub;
        end
      end
      OP1_ISSUE: state_d = OP1_WAIT;
      OP1_WAIT: begin
        if (bus.add_done) begin
          state_d   = OP2_ISSUE;
          r1_d      = bus.add_result;
          add_a_d   = bus.add_result[WIDTH-1:0];
          add_b_d   = m_q;
          add_sub_d = ~op_sub_q;
        end
      end
      OP2_ISSUE: state_d = OP2_WAIT;
      OP2_WAIT: begin
        if (bus.add_done) begin
          state_d  = FIN;
          result_d = final_select(op_sub_q, r1_q, bus.add_result);
        end
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with the state they belong to.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q     <= IDLE;
      r1_q        <= '0;
      add_start_q <= 1'b0;
      add_sub_q   <= 1'b0;
      add_a_q     <= '0;
      add_b_q     <= '0;
      result_q    <= '0;
      done_q      <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      r1_q        <= r1_d;
      add_start_q <= (state_d == OP1_ISSUE) || (state_d == OP2_ISSUE);
      add_sub_q   <= add_sub_d;
      add_a_q     <= add_a_d;
      add_b_q     <= add_b_d;
      result_q    <= result_d;
      done_q      <= (state_d == FIN);
      busy_q      <= (state_d != IDLE);
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      op_sub_q <= bus.op_sub;
      m_q      <= bus.in_m;
    end
  end

  assign bus.add_start    = add_start_q;
  assign bus.add_subtract = add_sub_q;
  assign bus.add_in_a     = add_a_q;
  assign bus.add_in_b     = add_b_q;
  assign bus.result       = result_q;
  assign bus.done         = done_q;
  assign bus.busy         = busy_q;

endmodule

// File: tb/tb_modadd_ctrl.sv
// Bench for modadd_ctrl: 2-cycle mpadder model, scoreboard queue of expected results
// filled by the stimulus and drained by a done-driven monitor.
module tb_modadd_ctrl;
  localparam int W = 1027;

  typedef struct {
    logic [W-1:0] exp;
    int           cyc;
  } exp_t;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  bit   inj_done = 1'b0;
  exp_t sb[$];
  int   nstart = 0;

  modadd_ctrl_if #(.WIDTH(W)) bus ();

  modadd_ctrl #(.WIDTH(W)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // mpadder model: result and done appear two cycles after add_start is sampled.
  bit           s1_v = 1'b0, s2_v = 1'b0;
  logic [W:0]   s1_r = '0, s2_r = '0;
  logic [W-1:0] cap_a = '0, cap_b = '0;
  logic         cap_s = 1'b0;

  always @(posedge clk) begin
    s1_v <= bus.add_start;
    s1_r <= bus.add_subtract ? ({1'b0, bus.add_in_a} - {1'b0, bus.add_in_b})
                             : ({1'b0, bus.add_in_a} + {1'b0, bus.add_in_b});
    s2_v <= s1_v;
    s2_r <= s1_r;
    if (bus.add_start) begin
      cap_a <= bus.add_in_a;
      cap_b <= bus.add_in_b;
      cap_s <= bus.add_subtract;
    end
  end

  assign bus.add_done   = s2_v | inj_done;
  assign bus.add_result = s2_r;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (low 256 bits)", name, act[255:0], exp[255:0]);
    end
  endtask

  function automatic logic [W-1:0] ref_mod(input bit sub, input logic [W-1:0] a,
                                           input logic [W-1:0] b, input logic [W-1:0] m);
    logic [W+1:0] t;
    if (sub) t = ({2'b0, a} + {2'b0, m} - {2'b0, b}) % {2'b0, m};
    else     t = ({2'b0, a} + {2'b0, b}) % {2'b0, m};
    return t[W-1:0];
  endfunction

  function automatic logic [W-1:0] rand_wide(input int bits);
    logic [1055:0] t;
    logic [W-1:0]  one, v;
    one = 1;
    for (int i = 0; i < 33; i++) t[i*32 +: 32] = $urandom;
    v = t[W-1:0];
    if (bits < W) v = v & ((one << bits) - one);
    return v;
  endfunction

  // Monitor: operand stability at each add_done, and result/latency/issue count at each done.
  always @(negedge clk) begin
    if (!resetn) begin
      nstart = 0;
    end else begin
      if (bus.add_start) nstart++;
      if (bus.add_done && bus.busy && !inj_done) begin
        check("add_in_a_stable", bus.add_in_a, cap_a);
        check("add_in_b_stable", bus.add_in_b, cap_b);
        check("add_subtract_stable", W'(bus.add_subtract), W'(cap_s));
      end
      if (bus.done) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done: got done=1 expected no pending operation");
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("result", bus.result, e.exp);
          check("latency", W'(cyc - e.cyc), W'(7));
          check("add_start_count", W'(nstart), W'(2));
        end
        nstart = 0;
      end
    end
  end

  task automatic wait_done();
    int n = 0;
    while (!bus.done && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("done_timeout", W'(bus.done), W'(1));
  endtask

  task automatic issue(input bit sub, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [W-1:0] m);
    exp_t e;
    @(negedge clk);
    bus.start  = 1'b1;
    bus.op_sub = sub;
    bus.in_a   = a;
    bus.in_b   = b;
    bus.in_m   = m;
    e.exp = ref_mod(sub, a, b, m);
    e.cyc = cyc;
    sb.push_back(e);
    @(negedge clk);
    bus.start  = 1'b0;
    bus.op_sub = ~sub;
    bus.in_a   = ~a;
    bus.in_b   = ~b;
    bus.in_m   = ~m;
  endtask

  task automatic run_op(input bit sub, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] m);
    issue(sub, a, b, m);
    wait_done();
  endtask

  initial begin
    logic [W-1:0] one, mb, a, b, m, held;
    bit           seen;
    int           bits;
    one = 1;
    bus.start = 1'b0; bus.op_sub = 1'b0;
    bus.in_a = '0; bus.in_b = '0; bus.in_m = '0;

    repeat (3) @(negedge clk);
    check("rst_result", bus.result, '0);
    check("rst_done", W'(bus.done), '0);
    check("rst_busy", W'(bus.busy), '0);
    check("rst_add_start", W'(bus.add_start), '0);
    check("rst_add_subtract", W'(bus.add_subtract), '0);
    check("rst_add_in_a", bus.add_in_a, '0);
    check("rst_add_in_b", bus.add_in_b, '0);
    resetn = 1'b1;

    run_op(1'b0, W'(7), W'(9), W'(13));
    run_op(1'b0, W'(3), W'(4), W'(13));
    run_op(1'b0, W'(6), W'(7), W'(13));
    run_op(1'b1, W'(3), W'(9), W'(13));
    run_op(1'b1, W'(9), W'(3), W'(13));
    run_op(1'b1, W'(5), W'(5), W'(13));
    mb = (one << 1025) + one;
    run_op(1'b0, mb - one, mb - one, mb);
    check("full_width_carry", bus.result, mb - W'(2));

    // Second start during an active operation must be ignored; then back-to-back.
    issue(1'b0, W'(3), W'(4), W'(13));
    @(negedge clk);
    bus.start = 1'b1; bus.op_sub = 1'b1; bus.in_a = W'(9); bus.in_b = W'(3); bus.in_m = W'(11);
    @(negedge clk);
    bus.start = 1'b0;
    wait_done();
    run_op(1'b1, W'(9), W'(3), W'(13));

    // Stray add_done while idle, in OP1_ISSUE and in FIN.
    held = bus.result;
    @(negedge clk); inj_done = 1'b1;
    @(negedge clk); inj_done = 1'b0;
    check("stray_idle_busy", W'(bus.busy), '0);
    check("stray_idle_result", bus.result, held);
    @(negedge clk);
    bus.start = 1'b1; bus.op_sub = 1'b0; bus.in_a = W'(10); bus.in_b = W'(11); bus.in_m = W'(13);
    sb.push_back('{exp: ref_mod(1'b0, W'(10), W'(11), W'(13)), cyc: cyc});
    @(negedge clk); bus.start = 1'b0; inj_done = 1'b1;
    @(negedge clk); inj_done = 1'b0;
    wait_done();
    inj_done = 1'b1;
    @(negedge clk); inj_done = 1'b0;
    check("stray_fin_busy", W'(bus.busy), '0);

    // Reset in OP1_WAIT aborts the operation; the late add_done must be ignored.
    issue(1'b0, W'(1), W'(2), W'(13));
    @(negedge clk);
    resetn = 1'b0;
    sb.delete();
    @(negedge clk);
    check("abort_busy", W'(bus.busy), '0);
    check("abort_result", bus.result, '0);
    resetn = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (bus.done) seen = 1'b1;
    end
    check("abort_no_done", W'(seen), '0);
    run_op(1'b1, W'(2), W'(8), W'(13));

    // Randomized operations with occasional boundary cases.
    for (int i = 0; i < 30; i++) begin
      bits = (i % 2 == 0) ? $urandom_range(16, 3) : $urandom_range(W - 1, 17);
      m = rand_wide(bits);
      m[bits-1] = 1'b1;
      a = rand_wide(W) % m;
      b = rand_wide(W) % m;
      if (i % 5 == 0) b = (a == '0) ? '0 : m - a;
      if (i % 7 == 0) b = a;
      run_op(1'(($urandom & 1)), a, b, m);
    end

    repeat (3) @(negedge clk);
    check("scoreboard_empty", W'(sb.size()), '0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no completion expected finish");
    $fatal(1, "timeout");
  end

endmodule
